// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signals of the unified memory arbiter.
// The arbiter uses the slave view; the environment (datapath plus RAM) uses the master view.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// Grants the single RAM port to instruction fetch or data access, data first.
// Define MEM_ARB_STARVE_GUARD_EN to force an instruction grant after STARVE_LIMIT data wins.
module mem_arbiter (
    input logic          CLK,
    input logic          nRST,
    mem_arbiter_if.slave bus
);
`ifdef MEM_ARB_STARVE_GUARD_EN
    parameter int STARVE_LIMIT = 4;
`endif

    typedef enum logic [1:0] {IDLE, INSTR, DATA} state_e;

    state_e state;
    state_e nextState;
    logic   dReq;
    logic   forceInstr;

    assign dReq = bus.dREN | bus.dWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= nextState;
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int                StreakW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_LIMIT);

    logic [StreakW-1:0] streak;
    logic               iDone;
    logic               dDone;

    assign iDone = (state == INSTR) && bus.iREN && bus.ramready;
    assign dDone = (state == DATA) && dReq && bus.ramready;

    // Counts data wins that kept a waiting fetch out; saturates so the guard stays armed.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            streak <= '0;
        else if (iDone)
            streak <= '0;
        else if (dDone && bus.iREN && (streak != StreakMax))
            streak <= streak + StreakW'(1);
    end

    assign forceInstr = bus.iREN && (streak == StreakMax);
`else
    assign forceInstr = 1'b0;
`endif

    always_comb begin
        nextState    = state;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        case (state)
            IDLE: begin
                if (forceInstr)    nextState = INSTR;
                else if (dReq)     nextState = DATA;
                else if (bus.iREN) nextState = INSTR;
            end
            INSTR: begin
                // A dropped request aborts silently: no strobe, no completion.
                if (!bus.iREN) begin
                    nextState = IDLE;
                end else begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = bus.iaddr;
                    if (bus.ramready) begin
                        bus.iwait = 1'b0;
                        bus.iload = bus.ramload;
                        nextState = IDLE;
                    end
                end
            end
            DATA: begin
                if (!dReq) begin
                    nextState = IDLE;
                end else begin
                    bus.ramaddr  = bus.daddr;
                    bus.ramstore = bus.dstore;
                    bus.ramWEN   = bus.dWEN;
                    bus.ramREN   = ~bus.dWEN;
                    if (bus.ramready) begin
                        bus.dwait = 1'b0;
                        bus.dload = bus.ramload;
                        nextState = IDLE;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level grant model predicts every cycle.
// Build with MEM_ARB_STARVE_GUARD_EN defined to exercise the starvation guard.
module tb_mem_arbiter;
    localparam int STARVE = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic CLK = 1'b0;
    logic nRST = 1'b0;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic        iw;
        logic        dw;
        logic [31:0] il;
        logic [31:0] dl;
    } busExp_t;

    typedef struct packed {
        logic        isData;
        logic [31:0] load;
    } doneExp_t;

    busExp_t  busQ[$];
    doneExp_t doneQ[$];
    int       doneLog[$];
    int       errors = 0;
    int       checks = 0;
    // Owner of the RAM port for the coming cycle: 0 nobody, 1 fetch, 2 data.
    int       owner = 0;
    int       streak = 0;
    bit       lastIDone;
    bit       lastDDone;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_iwait", bus.iwait, 1);
        checkOutput("rst_dwait", bus.dwait, 1);
        checkOutput("rst_iload", bus.iload, 0);
        checkOutput("rst_dload", bus.dload, 0);
        checkOutput("rst_ramREN", bus.ramREN, 0);
        checkOutput("rst_ramWEN", bus.ramWEN, 0);
        checkOutput("rst_ramaddr", bus.ramaddr, 0);
        checkOutput("rst_ramstore", bus.ramstore, 0);
    endtask

    task automatic idleInputs();
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = 0; bus.dstore = 0; bus.ramready = 0; bus.ramload = 0;
    endtask

    // Drives one cycle of inputs and predicts that cycle's outputs from who owns the port.
    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                                 input logic [31:0] da, input logic [31:0] ds, input logic rdy,
                                 input logic [31:0] ld);
        busExp_t  e;
        doneExp_t d;
        int       nextOwner;
        @(posedge CLK);
        #1;
        bus.iREN = ir; bus.iaddr = ia; bus.dREN = dr; bus.dWEN = dw;
        bus.daddr = da; bus.dstore = ds; bus.ramready = rdy; bus.ramload = ld;
        e = '0;
        e.iw = 1'b1;
        e.dw = 1'b1;
        nextOwner = owner;
        lastIDone = 0;
        lastDDone = 0;
        if (owner == 0) begin
            if (GUARD && ir && streak == STARVE) nextOwner = 1;
            else if (dr || dw)                   nextOwner = 2;
            else if (ir)                         nextOwner = 1;
        end else if (owner == 1) begin
            if (!ir) nextOwner = 0;
            else begin
                e.ren  = 1'b1;
                e.addr = ia;
                if (rdy) begin
                    e.iw = 1'b0;
                    e.il = ld;
                    d.isData = 1'b0;
                    d.load = ld;
                    doneQ.push_back(d);
                    lastIDone = 1;
                    streak = 0;
                    nextOwner = 0;
                end
            end
        end else begin
            if (!(dr || dw)) nextOwner = 0;
            else begin
                e.wen   = dw;
                e.ren   = !dw;
                e.addr  = da;
                e.store = ds;
                if (rdy) begin
                    e.dw = 1'b0;
                    e.dl = ld;
                    d.isData = 1'b1;
                    d.load = ld;
                    doneQ.push_back(d);
                    lastDDone = 1;
                    if (ir && streak < STARVE) streak++;
                    nextOwner = 0;
                end
            end
        end
        busQ.push_back(e);
        owner = nextOwner;
    endtask

    // Monitor: compares each predicted cycle and pops a completion whenever a wait drops.
    initial begin
        busExp_t  e;
        doneExp_t d;
        forever begin
            @(negedge CLK);
            if (busQ.size() != 0) begin
                e = busQ.pop_front();
                checkOutput("ramREN", bus.ramREN, e.ren);
                checkOutput("ramWEN", bus.ramWEN, e.wen);
                if (e.ren || e.wen) checkOutput("ramaddr", bus.ramaddr, e.addr);
                if (e.wen) checkOutput("ramstore", bus.ramstore, e.store);
                checkOutput("iwait", bus.iwait, e.iw);
                checkOutput("dwait", bus.dwait, e.dw);
                checkOutput("iload", bus.iload, e.il);
                checkOutput("dload", bus.dload, e.dl);
            end
            if (!bus.iwait || !bus.dwait) begin
                doneLog.push_back(bus.dwait ? 0 : 1);
                if (doneQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedDone: iwait=%b dwait=%b, expected no completion", bus.iwait, bus.dwait);
                end else begin
                    d = doneQ.pop_front();
                    checkOutput("donePort", bus.dwait, d.isData ? 0 : 1);
                    checkOutput("doneLoad", d.isData ? bus.dload : bus.iload, d.load);
                end
            end
        end
    end

    initial begin
        bit          iP, dP, dRd, dWr;
        logic [31:0] iA, dA, dS;
        int          instrSeen;
        idleInputs();
        #12;
        checkReset();
        #5 nRST = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h5555_5555);

        // Lone fetch; ramready in IDLE must be ignored.
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 1, 32'h8C01_0004);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 1, 32'h8C01_0004);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Conflict: write wins, fetch follows after turnaround.
        applyStimulus(1, 32'h44, 0, 1, 32'h100, 32'hDEAD_BEEF, 0, 0);
        applyStimulus(1, 32'h44, 0, 1, 32'h100, 32'hDEAD_BEEF, 1, 0);
        applyStimulus(1, 32'h44, 0, 0, 0, 0, 1, 32'h1111_2222);
        applyStimulus(1, 32'h44, 0, 0, 0, 0, 1, 32'h1111_2222);

        // Wait states on a read, with dREN and dWEN together afterwards.
        applyStimulus(0, 0, 1, 0, 32'h200, 32'h77, 0, 0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 1, 0, 32'h200, 32'h77, 0, 32'hBAD0_0000);
        applyStimulus(0, 0, 1, 0, 32'h200, 32'h77, 1, 32'h1234_5678);
        applyStimulus(0, 0, 1, 1, 32'h204, 32'h99, 0, 0);
        applyStimulus(0, 0, 1, 1, 32'h204, 32'h99, 1, 32'hFFFF_0000);

        // Abort of a granted fetch.
        applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 32'h80, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hABCD_0000);

        // Reset in the middle of a stalled write.
        applyStimulus(0, 0, 0, 1, 32'h300, 32'hCAFE_F00D, 0, 0);
        applyStimulus(0, 0, 0, 1, 32'h300, 32'hCAFE_F00D, 0, 0);
        #1 nRST = 1'b0;
        busQ.delete();
        doneQ.delete();
        owner = 0;
        streak = 0;
        #1 checkReset();
        @(posedge CLK);
        #1 checkReset();
        idleInputs();
        #1 nRST = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Starvation: fetch and read held high with an always-ready RAM.
        applyStimulus(1, 32'h500, 0, 0, 0, 0, 1, 32'h5000_0000);
        applyStimulus(1, 32'h500, 0, 0, 0, 0, 1, 32'h5000_0000);
        @(negedge CLK);
        #1 doneLog.delete();
        for (int k = 0; k < 48; k++) applyStimulus(1, 32'h500, 1, 0, 32'h600, 0, 1, k);
        @(negedge CLK);
        #1;
        checkOutput("starveCount", doneLog.size() >= 20, 1);
        if (GUARD) begin
            for (int k = 0; k < 6; k++) checkOutput("starveSeq", doneLog[k], (k == 4) ? 0 : 1);
        end else begin
            instrSeen = 0;
            foreach (doneLog[k]) if (doneLog[k] == 0) instrSeen++;
            checkOutput("starveNoFetch", instrSeen, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic with occasional aborts.
        iP = 0; dP = 0; dRd = 0; dWr = 0; iA = 0; dA = 0; dS = 0;
        for (int n = 0; n < 600; n++) begin
            if (!iP && $urandom_range(0, 2) == 0) begin
                iP = 1;
                iA = $urandom;
            end
            if (!dP && $urandom_range(0, 2) == 0) begin
                dP = 1;
                dA = $urandom;
                dS = $urandom;
                case ($urandom_range(0, 2))
                    0:       {dRd, dWr} = 2'b10;
                    1:       {dRd, dWr} = 2'b01;
                    default: {dRd, dWr} = 2'b11;
                endcase
            end
            if (iP && $urandom_range(0, 24) == 0) iP = 0;
            if (dP && $urandom_range(0, 24) == 0) dP = 0;
            applyStimulus(iP, iA, dP && dRd, dP && dWr, dA, dS, $urandom_range(0, 2) != 0, $urandom);
            if (lastIDone) iP = 0;
            if (lastDDone) dP = 0;
        end
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        #1;
        checkOutput("doneQEmpty", doneQ.size(), 0);
        checkOutput("busQEmpty", busQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single unified RAM port between the datapath's instruction-fetch requester and data-access requester in the pipelined processor. It sits between the datapath/cache interface and RAM, and grants one requester at a time through a registered grant FSM. Data accesses have priority so the MEM stage drains ahead of IF. An optional starvation guard bounds how long instruction fetch can be locked out.

## Interface
- STARVE_LIMIT, 4: consecutive data grants, while an instruction request is pending, before one instruction grant is forced. Used only when the guard is compiled in.
- CLK  input  1  system clock; all state updates on the rising edge
- nRST  input  1  asynchronous, active-low reset
- iREN  input  1  instruction read request
- iaddr  input  32  instruction word address
- iwait  output  1  low only in the cycle the instruction read completes
- iload  output  32  instruction read data, valid when iwait=0
- dREN  input  1  data read request
- dWEN  input  1  data write request
- daddr  input  32  data address
- dstore  input  32  data write value
- dwait  output  1  low only in the cycle the data access completes
- dload  output  32  data read data, valid when dwait=0
- ramREN  output  1  RAM read strobe
- ramWEN  output  1  RAM write strobe
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data
- ramready  input  1  RAM completes the current access this cycle

## Operation
- FSM states are IDLE, INSTR and DATA. The state is registered.
- **IDLE**
  - Drives no RAM strobes.
  - Next state is DATA if dREN|dWEN.
  - Otherwise next state is INSTR if iREN.
  - Otherwise it stays in IDLE.
- **DATA**
  - ramaddr=daddr and ramstore=dstore.
  - If dWEN, ramWEN=1 and ramREN=0. dWEN wins when dREN and dWEN are both set.
  - Otherwise ramREN=dREN.
  - dwait=~ramready and dload=ramload.
  - On ramready, the next state is IDLE.
- **INSTR**
  - ramREN=1 and ramaddr=iaddr.
  - iwait=~ramready and iload=ramload.
  - On ramready, the next state is IDLE.
- Requesters hold their request and address stable until their wait signal goes low.
- **Abort:** if the granted requester drops its request before ramready, strobes drop that cycle, the next state is IDLE, and no completion is signalled.
- The ungranted requester's wait is held at 1. This also holds in IDLE.
- iload and dload are zero whenever their port is not completing.
- Unused RAM outputs are zero.

## Timing
- **Reset values:** state=IDLE, iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, and the streak counter is 0.
- **Reset mid-access:** the FSM is forced to IDLE immediately (asynchronously), strobes drop, and the access is discarded.
- **Minimum latency:** request sampled in IDLE at cycle 0, grant registered at edge 1, completion in cycle 1 if ramready=1. Every access therefore takes at least 2 cycles.
- One IDLE turnaround cycle follows every completion or abort. Back-to-back accesses therefore complete at best every 2 cycles.
- **Simultaneous iREN and dREN/dWEN in IDLE:** data is granted. The exception is when the starvation guard fires (see Configuration).
- A ramready seen in IDLE is ignored.
- All outputs are combinational functions of state and inputs. There are no registered data paths.

## Configuration
- **MEM_ARB_STARVE_GUARD_EN defined:**
  - A counter (width clog2(STARVE_LIMIT+1)) increments on each DATA completion that occurs while iREN=1. It saturates at STARVE_LIMIT.
  - It clears on any INSTR completion.
  - In IDLE, if the count equals STARVE_LIMIT and iREN=1, INSTR is granted even when a data request is present.
- **Undefined:** no counter. Data always wins in IDLE, and instruction fetch may starve indefinitely.

## Test plan
- **Reset:** assert nRST=0 mid-DATA access with ramready=0 -> all outputs at reset values that cycle. After release with no requests: state IDLE, iwait=dwait=1.
- **Lone fetch:** iREN=1, iaddr=0x40, ramready=1, ramload=0x8C010004 -> ramREN=1 and ramaddr=0x40 in cycle 1, iwait=0 and iload=0x8C010004 in cycle 1, IDLE in cycle 2.
- **Conflict:** iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEADBEEF) together in IDLE -> DATA granted: ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF, iwait=1. After completion and IDLE, INSTR is granted.
- **Wait states:** dREN=1, ramready low for 3 cycles then high -> dwait=1 for 3 granted cycles, then 0 for exactly one cycle with dload=ramload.
- **Abort:** grant INSTR, drop iREN while ramready=0 -> ramREN=0 that cycle, next state IDLE, iwait never goes low.
- **Starvation (with MEM_ARB_STARVE_GUARD_EN, STARVE_LIMIT=4):** iREN held high, dREN held high -> 4 data completions, then an instruction grant, then data resumes. Without the macro: only data completions for 20+ accesses.
